// File: rtl/arbiter_rr.sv
// Registered N-requester arbiter: fixed-priority or round-robin search, grant
// lock while the holder keeps requesting, optional starvation limit (MAX_HOLD).
module arbiter_rr #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 0,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [0:N-1]   r,
  input  logic           mode,
  output logic [0:N-1]   g,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  // hold_cnt saturates at MAX_HOLD, or at 2^IDW-1 when the limit is disabled.
  localparam int HCW_MH = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HCW    = (MAX_HOLD == 0) ? IDW : HCW_MH;
  localparam int HC_SAT = (MAX_HOLD == 0) ? ((2 ** IDW) - 1) : MAX_HOLD;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [0:N-1]   g_q, g_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hold_q, hold_d;

  logic           holder_req;
  logic           others_req;
  logic           preempt;
  logic           rearb;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW:0]   rr_sum;
  logic [IDW-1:0] cand;

  assign holder_req = r[id_q];
  assign others_req = |(r & ~g_q);
  assign preempt    = (state_q == GRANTED) && holder_req && (MAX_HOLD != 0) &&
                      (hold_q == HCW'(HC_SAT)) && others_req;
  assign rearb      = (state_q == IDLE) || !holder_req || preempt;

  // Search order: 0..N-1 in fixed mode, ptr+1..ptr (wrapping) in round-robin.
  // On preemption the current holder is skipped.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      rr_sum = {1'b0, ptr_q} + (IDW+1)'(k + 1);
      if (rr_sum >= (IDW+1)'(N)) rr_sum = rr_sum - (IDW+1)'(N);
      cand = mode ? rr_sum[IDW-1:0] : IDW'(k);
      if (!win_found && r[cand] && !(preempt && (cand == id_q))) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (rearb) begin
      if (win_found) begin
        state_d       = GRANTED;
        g_d           = '0;
        g_d[win_idx]  = 1'b1;
        id_d          = win_idx;
        ptr_d         = win_idx;
        hold_d        = HCW'(1);
      end else begin
        state_d = IDLE;
        g_d     = '0;
        id_d    = '0;
      end
    end else if (hold_q != HCW'(HC_SAT)) begin
      hold_d = hold_q + HCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      id_q    <= '0;
      ptr_q   <= IDW'(N - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign g         = g_q;
  assign gnt_valid = (state_q == GRANTED);
  assign gnt_id    = id_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Bench for arbiter_rr: three instances (MAX_HOLD 0, 2, 3) share one stimulus;
// a per-instance reference model is compared every cycle, plus directed checks.
module tb_arbiter_rr;

  logic       clk;
  logic       reset_n;
  logic [0:3] r;
  logic       mode;

  logic [0:3] g_a  [3];
  logic       v_a  [3];
  logic [1:0] id_a [3];

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  arbiter_rr #(.N(4), .MAX_HOLD(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .r(r), .mode(mode),
    .g(g_a[0]), .gnt_valid(v_a[0]), .gnt_id(id_a[0]));
  arbiter_rr #(.N(4), .MAX_HOLD(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .r(r), .mode(mode),
    .g(g_a[1]), .gnt_valid(v_a[1]), .gnt_id(id_a[1]));
  arbiter_rr #(.N(4), .MAX_HOLD(3)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .r(r), .mode(mode),
    .g(g_a[2]), .gnt_valid(v_a[2]), .gnt_id(id_a[2]));

  // ---------------- reference model ----------------
  // holder = -1 when idle; cnt counts cycles of the current grant (unbounded).
  int m_hold [3];
  int m_ptr  [3];
  int m_cnt  [3];
  int mh_tab [3] = '{0, 2, 3};
  bit model_ok = 1'b0;

  function automatic int pick(input logic [0:3] rv, input logic md,
                              input int p, input int ex);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = md ? ((p + 1 + k) % 4) : k;
      if (rv[c] === 1'b1 && c != ex) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int  w;
    bit  others;
    for (int u = 0; u < 3; u++) begin
      if (!reset_n) begin
        m_hold[u] = -1;
        m_ptr[u]  = 3;
        m_cnt[u]  = 0;
      end else begin
        others = 1'b0;
        for (int i = 0; i < 4; i++)
          if (r[i] === 1'b1 && i != m_hold[u]) others = 1'b1;
        if (m_hold[u] < 0 || r[m_hold[u]] !== 1'b1) begin
          w = pick(r, mode, m_ptr[u], -1);
          m_hold[u] = w;
          if (w >= 0) begin
            m_ptr[u] = w;
            m_cnt[u] = 1;
          end
        end else if (mh_tab[u] != 0 && m_cnt[u] >= mh_tab[u] && others) begin
          w = pick(r, mode, m_ptr[u], m_hold[u]);
          m_hold[u] = w;
          m_ptr[u]  = w;
          m_cnt[u]  = 1;
        end else begin
          m_cnt[u] = m_cnt[u] + 1;
        end
      end
    end
    if (!reset_n) model_ok = 1'b1;
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    logic [0:3] eg;
    logic [1:0] eid;
    if (model_ok) begin
      for (int u = 0; u < 3; u++) begin
        eg  = '0;
        eid = '0;
        if (m_hold[u] >= 0) begin
          eg[m_hold[u]] = 1'b1;
          eid = 2'(m_hold[u]);
        end
        n_checks++;
        if (g_a[u] !== eg || v_a[u] !== (m_hold[u] >= 0) || id_a[u] !== eid) begin
          n_fail++;
          $display("FAIL model_cmp inst%0d t=%0t: g=%b valid=%b id=%0d, required g=%b valid=%b id=%0d",
                   u, $time, g_a[u], v_a[u], id_a[u], eg, (m_hold[u] >= 0), eid);
        end
        n_checks++;
        if (!$onehot0(g_a[u]) || v_a[u] !== (|g_a[u]) ||
            (v_a[u] && g_a[u][id_a[u]] !== 1'b1) || (!v_a[u] && id_a[u] !== 2'd0)) begin
          n_fail++;
          $display("FAIL consistency inst%0d t=%0t: g=%b valid=%b id=%0d, required one-hot g matching valid/id",
                   u, $time, g_a[u], v_a[u], id_a[u]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge: apply inputs, return at the next falling edge.
  task automatic drive(input logic [0:3] rv, input logic md, input logic rn);
    r       = rv;
    mode    = md;
    reset_n = rn;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int u, input logic [0:3] eg);
    int eid;
    eid = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) eid = i;
    n_checks++;
    if (g_a[u] !== eg || id_a[u] !== 2'(eid) || v_a[u] !== (|eg)) begin
      n_fail++;
      $display("FAIL %s inst%0d: g=%b id=%0d valid=%b, required g=%b id=%0d valid=%b",
               nm, u, g_a[u], id_a[u], v_a[u], eg, eid, (|eg));
    end
  endtask

  // ---------------- directed stimulus ----------------
  logic [0:3] fp_tab [16];
  logic [0:3] rr_r   [5];
  logic [0:3] rr_g   [10];
  logic [0:3] rv;

  initial begin
    fp_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0010,
               4'b0100, 4'b0100, 4'b0100, 4'b0100,
               4'b1000, 4'b1000, 4'b1000, 4'b1000,
               4'b1000, 4'b1000, 4'b1000, 4'b1000};
    rr_g = '{4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0010,
             4'b0010, 4'b0001, 4'b0001, 4'b1000, 4'b1000};
    rr_r = '{4'b1111, 4'b0111, 4'b1011, 4'b1101, 4'b1110};

    r = 4'b1111; mode = 1'b0; reset_n = 1'b0;
    @(negedge clk);

    // Reset behaviour, including reset in the middle of a grant
    drive(4'b1111, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b0);
    for (int u = 0; u < 3; u++) chk("reset_idle", u, 4'b0000);
    drive(4'b1111, 1'b0, 1'b1);
    chk("first_grant", 0, 4'b1000);
    drive(4'b1111, 1'b0, 1'b0);
    chk("reset_mid_grant", 0, 4'b0000);

    // Fixed-priority lock and release
    drive(4'b0110, 1'b0, 1'b1);
    chk("fixed_grant", 0, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0110, 1'b0, 1'b1);
      chk("fixed_lock", 0, 4'b0100);
    end
    drive(4'b1010, 1'b0, 1'b1);
    chk("fixed_release_no_bubble", 0, 4'b1000);
    drive(4'b0000, 1'b0, 1'b1);
    chk("fixed_idle", 0, 4'b0000);

    // Round-robin fairness with MAX_HOLD=2
    drive(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(4'b1111, 1'b1, 1'b1);
      chk("rr_fair_seq", 1, rr_g[i]);
    end

    // Round-robin release sequence with pointer wrap (MAX_HOLD=0)
    drive(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(rr_r[i], 1'b1, 1'b1);
      chk("rr_release_seq", 0, rr_g[2 * (i % 4)]);
    end

    // Starvation limit in fixed mode (MAX_HOLD=3)
    drive(4'b1001, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(4'b1001, 1'b0, 1'b1);
      chk("starve_limit", 2, (i >= 3 && i < 6) ? 4'b0001 : 4'b1000);
    end
    for (int i = 0; i < 6; i++) begin
      drive(4'b1000, 1'b0, 1'b1);
      chk("sole_hold", 2, 4'b1000);
    end

    // Fixed-priority table from idle, one-cycle requests
    drive(4'b0000, 1'b0, 1'b0);
    for (int p = 0; p < 16; p++) begin
      rv = 4'(p);
      drive(rv, 1'b0, 1'b1);
      chk("fp_table", 0, fp_tab[p]);
      drive(4'b0000, 1'b0, 1'b1);
      chk("fp_table_gap", 0, 4'b0000);
    end

    // Mixed traffic: model-only checking, sticky requests, mode flips, resets
    rv = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) rv = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      drive(rv, mode, ($urandom_range(0, 59) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
